// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, line idle level and the receiver
// state encoding used by both the receiver and the transmitter.
package uart_pkg;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_DATA_BITS    = 8;

    // Serial line rests high between frames
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    // A frame is in flight from the start-bit check up to the stop sample
    function automatic logic state_is_busy(input uart_state_e s);
        return (s == START) || (s == DATA) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so an idle-high line does not look like activity out of reset.
module uart_sync
    import uart_pkg::*;
#(
    parameter logic RESET_VALUE = LINE_IDLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; only q is safe to use in clk-domain logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The start bit is re-checked at mid-bit, data bits are
// sampled at their centres LSB-first, the stop bit is checked, and the byte is
// offered on a valid/ready interface. Framing errors and overruns are reported
// as one-cycle pulses. CLKS_PER_BIT must be even and >= 4; DATA_BITS >= 2.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    // Counter values on which a sample is taken (counter restarts at 0)
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state;
    uart_state_e          state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 deliver;
    logic                 stop_bad;

    uart_sync #(
        .RESET_VALUE(LINE_IDLE)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rxd),
        .q    (rx_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bit timing and sampling decisions from the synchronized line
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (rx_s == 1'b0) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_s == 1'b0) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        // Too short to be a start bit: treat as a glitch
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s == 1'b1) begin
                        // Leave at mid-stop so a following start edge is caught
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                cnt_next = '0;
                // A held-low line must return high before a new frame can start
                if (rx_s == 1'b1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Bit counter, bit index and data shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            cnt       <= cnt_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
        end
    end

    // Output handshake: hold the byte until consumed, drop newcomers on overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = state_is_busy(state);

endmodule
